// File: rtl/mult_datapath.sv
// rtl/mult_datapath.sv - X/A/B register datapath for a shift-add signed multiplier.
// Add/sub of S into {X,A} gated by B[0], arithmetic right shift of {X,A,B}.
module mult_datapath (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Clr_XA,
  input  logic        Ld_B,
  input  logic        Add,
  input  logic        Sub,
  input  logic        Shift_En,
  input  logic [7:0]  S,
  output logic [7:0]  Aval,
  output logic [7:0]  Bval,
  output logic        X,
  output logic        M_bit,
  output logic [15:0] Product
);

  logic       x_r;
  logic [7:0] a_r;
  logic [7:0] b_r;
  logic [8:0] operand;
  logic [8:0] sum;

  // Subtract is two's complement: invert the sign-extended operand and add one.
  always_comb begin
    operand = Sub ? ~{S[7], S} : {S[7], S};
    sum     = {a_r[7], a_r} + operand + {8'd0, Sub};
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      x_r <= 1'b0;
      a_r <= 8'h00;
      b_r <= 8'h00;
    end else if (Clr_XA || Ld_B) begin
      if (Clr_XA) begin
        x_r <= 1'b0;
        a_r <= 8'h00;
      end
      if (Ld_B) begin
        b_r <= S;
      end
    end else if (Add) begin
      if (b_r[0]) begin
        x_r <= sum[8];
        a_r <= sum[7:0];
      end
    end else if (Shift_En) begin
      a_r <= {x_r, a_r[7:1]};
      b_r <= {a_r[0], b_r[7:1]};
    end
  end

  assign X       = x_r;
  assign Aval    = a_r;
  assign Bval    = b_r;
  assign M_bit   = b_r[0];
  assign Product = {a_r, b_r};

endmodule

// File: tb/tb_mult_datapath.sv
// tb/tb_mult_datapath.sv - directed self-checking bench for mult_datapath.
module tb_mult_datapath;

  logic        Clk = 1'b0;
  logic        Reset, Clr_XA, Ld_B, Add, Sub, Shift_En;
  logic [7:0]  S;
  logic [7:0]  Aval, Bval;
  logic        X, M_bit;
  logic [15:0] Product;

  int total  = 0;
  int passed = 0;

  mult_datapath dut (
    .Clk(Clk), .Reset(Reset), .Clr_XA(Clr_XA), .Ld_B(Ld_B), .Add(Add),
    .Sub(Sub), .Shift_En(Shift_En), .S(S), .Aval(Aval), .Bval(Bval),
    .X(X), .M_bit(M_bit), .Product(Product)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic idle();
    Reset = 0; Clr_XA = 0; Ld_B = 0; Add = 0; Sub = 0; Shift_En = 0;
  endtask

  // Apply the current inputs for one edge, then sample 1 time unit later.
  task automatic cyc();
    @(posedge Clk);
    #1;
    idle();
  endtask

  task automatic mult(input logic [7:0] b, input logic [7:0] s, input logic [15:0] exp, input string tag);
    Clr_XA = 1; Ld_B = 1; S = b; cyc();
    for (int i = 0; i < 8; i++) begin
      Add = 1; Sub = (i == 7); S = s; cyc();
      Shift_En = 1; cyc();
    end
    check(tag, Product, exp);
  endtask

  initial begin
    idle();
    S = 8'h00;
    @(posedge Clk); #1;

    // Reset overrides every other control
    Reset = 1; Clr_XA = 1; Ld_B = 1; Add = 1; Sub = 1; Shift_En = 1; S = 8'hFF;
    cyc();
    check("rst_x", {15'd0, X}, 16'd0);
    check("rst_a", {8'd0, Aval}, 16'h0000);
    check("rst_b", {8'd0, Bval}, 16'h0000);
    check("rst_prod", Product, 16'h0000);

    Ld_B = 1; S = 8'h07; cyc();
    Clr_XA = 1; S = 8'h55; cyc();
    check("ldb_b", {8'd0, Bval}, 16'h0007);
    check("ldb_m", {15'd0, M_bit}, 16'd1);
    check("clr_a", {7'd0, X, Aval}, 16'h0000);

    Add = 1; S = 8'hC5; cyc();
    check("add_xa", {7'd0, X, Aval}, 16'h01C5);
    check("add_b", {8'd0, Bval}, 16'h0007);

    Shift_En = 1; cyc();
    check("shift_xab", {X, Aval, Bval[7:1]}, {1'b1, 8'hE2, 7'h41});
    check("shift_b", {8'd0, Bval}, 16'h0083);

    Clr_XA = 1; Ld_B = 1; S = 8'h07; cyc();
    check("clr_ld_both", {7'd0, X, Aval}, 16'h0000);
    check("clr_ld_b", {8'd0, Bval}, 16'h0007);

    Add = 1; Sub = 1; S = 8'hC5; cyc();
    check("sub_xa", {7'd0, X, Aval}, 16'h003B);

    cyc(); cyc(); cyc();
    check("hold", {X, Aval, Bval[7:1]}, {1'b0, 8'h3B, 7'h03});

    Sub = 1; S = 8'h11; cyc();
    Sub = 1; cyc();
    check("sub_only", {X, Aval, Bval[7:1]}, {1'b0, 8'h3B, 7'h03});

    mult(8'h07, 8'hC5, 16'hFE63, "mult_7xC5");
    mult(8'h80, 8'h80, 16'h4000, "mult_80x80");
    mult(8'hFF, 8'hFF, 16'h0001, "mult_FFxFF");
    mult(8'h7F, 8'h7F, 16'h3F01, "mult_7Fx7F");
    mult(8'h05, 8'hFD, 16'hFFF1, "mult_5xFD");

    // -128 - (-128) wraps to zero
    Clr_XA = 1; Ld_B = 1; S = 8'h01; cyc();
    Add = 1; S = 8'h80; cyc();
    check("load_m128", {7'd0, X, Aval}, 16'h0180);
    Add = 1; Sub = 1; S = 8'h80; cyc();
    check("wrap_sub", {7'd0, X, Aval}, 16'h0000);

    Add = 1; S = 8'h10; cyc();
    Ld_B = 1; S = 8'h06; cyc();
    check("setup_a10", {7'd0, X, Aval}, 16'h0010);
    Add = 1; S = 8'h7F; cyc();
    check("add_m0", {X, Aval, Bval[7:1]}, {1'b0, 8'h10, 7'h03});
    check("add_m0_b0", {15'd0, Bval[0]}, 16'd0);

    Ld_B = 1; S = 8'h05; cyc();
    Add = 1; Shift_En = 1; S = 8'h01; cyc();
    check("add_beats_shift", {7'd0, X, Aval}, 16'h0011);
    check("add_beats_shift_b", {8'd0, Bval}, 16'h0005);

    Clr_XA = 1; Add = 1; S = 8'h22; cyc();
    check("clr_beats_add", {7'd0, X, Aval}, 16'h0000);

    // Reset in the middle of a multiply leaves nothing behind
    Clr_XA = 1; Ld_B = 1; S = 8'h07; cyc();
    Add = 1; S = 8'hC5; cyc();
    Shift_En = 1; cyc();
    Add = 1; S = 8'hC5; cyc();
    Reset = 1; Add = 1; S = 8'hC5; cyc();
    check("rst_mid_prod", Product, 16'h0000);
    check("rst_mid_x", {15'd0, X}, 16'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule
